// File: rtl/atconv_sequencer.sv
// atconv_sequencer: control/address sequencer for the atrous-convolution engine.
//
// It walks the image pixel by pixel with a dilated 3x3 kernel. Out-of-range taps are
// clamped to the image edge, which gives replicate padding. For each pixel it issues
// nine tap strobes and then one layer-0 write. After the last pixel it runs 2x2
// stride-2 max-pool reads from layer 0 and writes each result to layer 1. The
// datapath is external and only follows the strobes produced here.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   ready       image ready; sampled only in idle
//   busy        high from start until the end of the last layer-1 write
//   done        one-cycle pulse when the job completes
//   iaddr       image-ROM address {row, col}
//   tap_en      datapath accumulates idata * kernel[tap_sel]
//   tap_sel     kernel index 0..8, row-major
//   acc_clr     with tap_en: load instead of accumulate
//   cwr         layer memory write strobe
//   caddr_wr    layer memory write address
//   crd         layer memory read strobe (data valid next cycle)
//   caddr_rd    layer memory read address
//   csel        0 = layer 0, 1 = layer 1
//   pool_en     datapath captures cdata_rd into the max register
//   pool_first  with pool_en: load instead of max-compare
module atconv_sequencer #(
  parameter int unsigned IMG_LOG2 = 6,
  parameter int unsigned DIL      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [2*IMG_LOG2-1:0] iaddr,
  output logic                  tap_en,
  output logic [3:0]            tap_sel,
  output logic                  acc_clr,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic                  crd,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  output logic                  csel,
  output logic                  pool_en,
  output logic                  pool_first
);

  localparam int unsigned AW   = 2 * IMG_LOG2;        // pixel index width
  localparam int unsigned OW   = 2 * (IMG_LOG2 - 1);  // pool output index width
  localparam int          Side = 1 << IMG_LOG2;

  typedef enum logic [2:0] {
    StIdle,
    StConvTap,
    StWr0,
    StPoolRd,
    StPoolLast,
    StWr1,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [3:0]      tap_q, tap_d;
  logic [OW-1:0]   out_q, out_d;
  logic [1:0]      j_q, j_d;

  // Kernel row/col position (0..2) of the tap being presented next cycle.
  logic [1:0]      kr, kc;

  // Next values of the registered outputs.
  logic            busy_d, done_d, tap_en_d, acc_clr_d, cwr_d, crd_d, csel_d;
  logic            pool_en_d, pool_first_d;
  logic [3:0]      tap_sel_d;
  logic [AW-1:0]   iaddr_d, caddr_wr_d, caddr_rd_d;

  // Offsets a coordinate by -DIL, 0 or +DIL (k = 0, 1, 2) and clamps it to the image.
  function automatic logic [IMG_LOG2-1:0] clamp_off(input logic [IMG_LOG2-1:0] base,
                                                    input logic [1:0]          k);
    int v;
    v = int'(base);
    if (k == 2'd0) begin
      v = v - int'(DIL);
    end else if (k == 2'd2) begin
      v = v + int'(DIL);
    end
    if (v < 0) begin
      return '0;
    end
    if (v > Side - 1) begin
      return '1;
    end
    return IMG_LOG2'(v);
  endfunction

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    tap_d   = tap_q;
    out_d   = out_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: begin
        if (ready) begin
          state_d = StConvTap;
          pix_d   = '0;
          tap_d   = '0;
        end
      end
      StConvTap: begin
        if (tap_q == 4'd8) begin
          state_d = StWr0;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      StWr0: begin
        tap_d = '0;
        if (pix_q == '1) begin
          state_d = StPoolRd;
          out_d   = '0;
          j_d     = '0;
        end else begin
          state_d = StConvTap;
          pix_d   = pix_q + AW'(1);
        end
      end
      StPoolRd: begin
        if (j_q == 2'd3) begin
          state_d = StPoolLast;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      StPoolLast: begin
        state_d = StWr1;
      end
      StWr1: begin
        j_d = '0;
        if (out_q == '1) begin
          state_d = StDone;
        end else begin
          state_d = StPoolRd;
          out_d   = out_q + OW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    if (tap_d >= 4'd6) begin
      kr = 2'd2;
      kc = 2'(tap_d - 4'd6);
    end else if (tap_d >= 4'd3) begin
      kr = 2'd1;
      kc = 2'(tap_d - 4'd3);
    end else begin
      kr = 2'd0;
      kc = tap_d[1:0];
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d       = (state_d != StIdle) && (state_d != StDone);
    done_d       = (state_d == StDone);
    tap_en_d     = (state_d == StConvTap);
    tap_sel_d    = tap_en_d ? tap_d : 4'd0;
    acc_clr_d    = tap_en_d && (tap_d == 4'd0);
    iaddr_d      = '0;
    if (tap_en_d) begin
      iaddr_d = {clamp_off(pix_d[AW-1:IMG_LOG2], kr), clamp_off(pix_d[IMG_LOG2-1:0], kc)};
    end
    cwr_d        = (state_d == StWr0) || (state_d == StWr1);
    csel_d       = (state_d == StWr1);
    caddr_wr_d   = '0;
    if (state_d == StWr0) begin
      caddr_wr_d = pix_d;
    end else if (state_d == StWr1) begin
      caddr_wr_d = AW'(out_d);
    end
    crd_d        = (state_d == StPoolRd);
    // Pool window: row = {pr, j[1]}, col = {pc, j[0]}.
    caddr_rd_d   = '0;
    if (crd_d) begin
      caddr_rd_d = {out_d[OW-1:IMG_LOG2-1], j_d[1], out_d[IMG_LOG2-2:0], j_d[0]};
    end
    // Read data lags the strobe by a cycle, so capture runs one cycle behind.
    pool_en_d    = (crd_d && (j_d != 2'd0)) || (state_d == StPoolLast);
    pool_first_d = crd_d && (j_d == 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pix_q      <= '0;
      tap_q      <= '0;
      out_q      <= '0;
      j_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iaddr      <= '0;
      tap_en     <= 1'b0;
      tap_sel    <= '0;
      acc_clr    <= 1'b0;
      cwr        <= 1'b0;
      caddr_wr   <= '0;
      crd        <= 1'b0;
      caddr_rd   <= '0;
      csel       <= 1'b0;
      pool_en    <= 1'b0;
      pool_first <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      tap_q      <= tap_d;
      out_q      <= out_d;
      j_q        <= j_d;
      busy       <= busy_d;
      done       <= done_d;
      iaddr      <= iaddr_d;
      tap_en     <= tap_en_d;
      tap_sel    <= tap_sel_d;
      acc_clr    <= acc_clr_d;
      cwr        <= cwr_d;
      caddr_wr   <= caddr_wr_d;
      crd        <= crd_d;
      caddr_rd   <= caddr_rd_d;
      csel       <= csel_d;
      pool_en    <= pool_en_d;
      pool_first <= pool_first_d;
    end
  end

endmodule

// File: doc/atconv_sequencer.md
Name: atconv_sequencer

Overview:
Control/address sequencer for the atrous-convolution engine. It walks the 64x64 input image with a dilation-2 3x3 kernel and replicate padding, drives the image-ROM address and per-tap MAC strobes, and schedules layer-0 writes. It then runs 2x2 stride-2 max-pool reads/writes between layer 0 and layer 1. The arithmetic datapath (MAC, bias, ReLU, max, rounding, cdata_wr) is external and obeys this block's strobes.

Parameters:
IMG_LOG2, 6, log2 of image side (64); iaddr = {row, col}
DIL, 2, kernel dilation in pixels

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ready  in  1  image ready; sampled only in IDLE
busy  out  1  high from start until end of last layer-1 write
done  out  1  one-cycle pulse when the job completes
iaddr  out  12  image-ROM address; idata valid same cycle
tap_en  out  1  datapath accumulates idata*kernel[tap_sel] at end of cycle
tap_sel  out  4  kernel index 0..8, row-major, offsets (dr,dc) in {-DIL,0,+DIL}^2
acc_clr  out  1  with tap_en: load instead of accumulate (tap 0)
cwr  out  1  layer memory write strobe
caddr_wr  out  12  layer memory write address
crd  out  1  layer memory read strobe; cdata_rd valid next cycle
caddr_rd  out  12  layer memory read address
csel  out  1  0 = layer 0, 1 = layer 1
pool_en  out  1  datapath captures cdata_rd into max register
pool_first  out  1  with pool_en: load instead of max-compare

Behaviour:
- Reset (async): state IDLE, pixel/output counters 0, all outputs 0. Reset mid-job aborts immediately; the next ready restarts at pixel 0.
- All outputs are registered.
- States: IDLE, CONV_TAP, WR0, POOL_RD, POOL_LAST, WR1, DONE.
- IDLE: on clock edge with ready=1: busy<=1, go to CONV_TAP with tap 0 of pixel 0 presented.
- CONV_TAP (9 cycles per pixel, k=0..8):
  - tap_en=1, tap_sel=k, acc_clr=(k==0).
  - iaddr = {clamp(r+dr), clamp(c+dc)}, clamp to [0,63].
  - After k=8, go to WR0.
- WR0 (1 cycle): cwr=1, csel=0, caddr_wr=pixel index, tap_en=0.
  - Pixel < 4095: next pixel, CONV_TAP.
  - Pixel 4095: POOL_RD, output 0.
- POOL_RD (4 cycles, j=0..3) for output (pr,pc):
  - crd=1, csel=0.
  - caddr_rd order: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1), i.e. row*64+col.
  - pool_en=1 in cycles j=1..3; pool_first=1 at j=1.
- POOL_LAST (1 cycle): crd=0, pool_en=1 (captures 4th read).
- WR1 (1 cycle): cwr=1, csel=1, caddr_wr=pr*32+pc.
  - Output < 1023: next output, POOL_RD.
  - Output 1023: DONE.
- DONE (1 cycle): busy=0, done=1, then IDLE.
- Strobes are 0 in every state not listed. cwr and crd are never both high.
- Cycle budget: 10 cycles per conv pixel, 6 per pool output. busy high for exactly 4096*10 + 1024*6 = 47104 cycles.
- ready while busy (or in DONE) is ignored. ready held high after DONE starts a new job from IDLE.
- Counters do not wrap mid-job; the terminal pixel/output drives the state change.

Test Plan:
- Reset values: assert reset mid-cycle with no clock -> every output reads 0 immediately. Release, ready=0 for 20 cycles -> busy stays 0.
- Pixel 0 corner padding: ready=1 -> tap_sel 0..8 present iaddr 0,0,2,0,0,2,128,128,130 with acc_clr only on tap 0. Next cycle cwr=1, csel=0, caddr_wr=0.
- Pixel 4095 corner: iaddr 3965,3967,3967,4093,4095,4095,4093,4095,4095, then WR0 caddr_wr=4095. The next cycle is POOL_RD with caddr_rd=0.
- Last pool output (31,31): caddr_rd 4030,4031,4094,4095 with crd=1, csel=0. pool_en in the following 4 cycles, pool_first on the first. Then cwr=1, csel=1, caddr_wr=1023.
- Job length: count busy-high cycles -> 47104, done pulses once in the cycle busy first reads 0. ready toggled during busy -> no effect on addresses or count.
- Abort: async reset at pixel 100 tap 4 -> outputs 0 at once. Re-assert ready -> iaddr sequence restarts with pixel 0 tap 0 (iaddr 0).
